// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants, saturation helpers and mixer state enum
package audio_pkg;

  localparam int BITDEPTH_DEF = 14;
  localparam int MIDSCALE     = 2 ** (BITDEPTH_DEF - 1);
  localparam int SAT_MAX_DEF  = MIDSCALE - 1;
  localparam int SAT_MIN_DEF  = -MIDSCALE;
  // Master volume is a fixed-point gain with 128 meaning unity.
  localparam int GAIN_SHIFT   = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE
  } mix_state_e;

  function automatic int midscale(input int bitdepth);
    return 2 ** (bitdepth - 1);
  endfunction

  function automatic int acc_width(input int bitdepth, input int num_voices);
    return bitdepth + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/pdm_dac.sv
// rtl/pdm_dac.sv - first-order error-feedback delta-sigma modulator, one bit per clk
module pdm_dac #(
  parameter int BITDEPTH = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITDEPTH-1:0] sample,
  output logic                pdm_out
);

  logic [BITDEPTH-1:0] err_q, err_d;
  logic                pdm_q, pdm_d;
  logic [BITDEPTH:0]   sum;

  // Carry out of the error accumulator is the output bit; the remainder is fed back.
  always_comb begin
    sum   = {1'b0, err_q} + {1'b0, sample};
    err_d = sum[BITDEPTH-1:0];
    pdm_d = sum[BITDEPTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      err_q <= err_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/voice_mixer_pdm.sv
// rtl/voice_mixer_pdm.sv - serial voice summer with master volume, saturation and PDM output
module voice_mixer_pdm
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int BITDEPTH   = BITDEPTH_DEF,
  parameter int VOL_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_clock,
  input  logic [NUM_VOICES*BITDEPTH-1:0] voices,
  input  logic [VOL_BITS-1:0]            volume,
  output logic [BITDEPTH-1:0]            mix_out,
  output logic                           mix_valid,
  output logic                           pdm_out,
  output logic                           overrun
);

  localparam int ACC_W  = acc_width(BITDEPTH, NUM_VOICES);
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PROD_W = ACC_W + VOL_BITS + 1;

  localparam logic signed [ACC_W-1:0]  MID_ACC  = ACC_W'(midscale(BITDEPTH));
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'(midscale(BITDEPTH) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(-midscale(BITDEPTH));
  localparam logic [BITDEPTH-1:0]      MID_OUT  = BITDEPTH'(midscale(BITDEPTH));
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(NUM_VOICES - 1);

  mix_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [VOL_BITS-1:0]       vol_q, vol_d;
  logic [BITDEPTH-1:0]       mix_q, mix_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      sc_q, sc_d, sc2_q, sc2_d;

  logic                      trigger;
  logic [BITDEPTH-1:0]       voice_sel;
  logic signed [ACC_W-1:0]   voice_off;
  logic signed [PROD_W-1:0]  prod, scaled;
  logic [BITDEPTH-1:0]       sat;

  // Falling edge seen one clk after sampling, giving voices half a sample period to settle.
  assign trigger   = sc2_q & ~sc_q;
  assign voice_sel = voices[idx_q*BITDEPTH +: BITDEPTH];
  assign voice_off = $signed(ACC_W'(voice_sel)) - MID_ACC;
  assign prod      = $signed(PROD_W'(acc_q)) * $signed(PROD_W'({1'b0, vol_q}));
  assign scaled    = prod >>> GAIN_SHIFT;

  always_comb begin
    if (scaled > SAT_MAX) begin
      sat = {1'b0, {(BITDEPTH-1){1'b1}}};
    end else if (scaled < SAT_MIN) begin
      sat = {1'b1, {(BITDEPTH-1){1'b0}}};
    end else begin
      sat = scaled[BITDEPTH-1:0];
    end
  end

  always_comb begin
    sc_d      = sample_clock;
    sc2_d     = sc_q;
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    vol_d     = vol_q;
    mix_d     = mix_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ACCUM;
          acc_d   = '0;
          vol_d   = volume;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + voice_off;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = SCALE;
      end
      SCALE: begin
        mix_d   = sat + MID_OUT;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (trigger && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      vol_q     <= '0;
      mix_q     <= MID_OUT;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sc_q      <= 1'b0;
      sc2_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      vol_q     <= vol_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      sc_q      <= sc_d;
      sc2_q     <= sc2_d;
    end
  end

  assign mix_out   = mix_q;
  assign mix_valid = valid_q;
  assign overrun   = overrun_q;

  pdm_dac #(.BITDEPTH(BITDEPTH)) u_pdm_dac (
    .clk     (clk),
    .rst     (rst),
    .sample  (mix_q),
    .pdm_out (pdm_out)
  );

endmodule
